// File: rtl/cmd_pkt_if.sv
// Byte-stream and command-packet signals between uart_rcv, the assembler and the consumer.
interface cmd_pkt_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic        pkt_err;

  // Assembler side
  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy,
    output clr_rx_rdy, cmd_rdy, cmd, data, pkt_err
  );

  // Environment side: byte source plus packet consumer
  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy,
    input  clr_rx_rdy, cmd_rdy, cmd, data, pkt_err
  );
endinterface

// File: rtl/cmd_pkt_assembler.sv
// Assembles {cmd, data_hi, data_lo} byte triples from uart_rcv into command packets.
// A partial packet is dropped (with a pkt_err pulse) when the inter-byte gap runs out.
module cmd_pkt_assembler #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic      clk,
  input  logic      rst_n,
  cmd_pkt_if.slave  bus
);

  localparam int unsigned TW = 20;
  localparam int unsigned BW = 8;
  localparam int unsigned DW = 16;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  state_e         state_q;
  logic [TW-1:0]  timer_q;
  logic [BW-1:0]  cmd_shadow_q;
  logic [BW-1:0]  hi_shadow_q;
  logic [BW-1:0]  cmd_q;
  logic [DW-1:0]  data_q;
  logic           cmd_rdy_q;
  logic           pkt_err_q;

  logic           accept_d;
  logic           timeout_d;

  // A waiting byte is always taken; the acknowledge goes back in the same cycle
  assign accept_d       = bus.rx_rdy;
  assign bus.clr_rx_rdy = accept_d;

  // Timeout only counts while a packet is partially received; an accept pre-empts it
  assign timeout_d = (state_q != IDLE) && !accept_d && (timer_q == TMO_LAST);

  assign bus.cmd_rdy = cmd_rdy_q;
  assign bus.cmd     = cmd_q;
  assign bus.data    = data_q;
  assign bus.pkt_err = pkt_err_q;

  // Packet FSM, inter-byte timer, shadow and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      cmd_shadow_q <= '0;
      hi_shadow_q  <= '0;
      cmd_q        <= '0;
      data_q       <= '0;
      cmd_rdy_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
    end else begin
      pkt_err_q <= 1'b0;
      // Consumer clear; a completion later in this block overrides it
      if (bus.clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
      end
      if (accept_d) begin
        timer_q <= '0;
        case (state_q)
          IDLE: begin
            cmd_shadow_q <= bus.rx_data;
            cmd_rdy_q    <= 1'b0;
            state_q      <= HIGH;
          end
          HIGH: begin
            hi_shadow_q <= bus.rx_data;
            state_q     <= LOW;
          end
          LOW: begin
            cmd_q     <= cmd_shadow_q;
            data_q    <= {hi_shadow_q, bus.rx_data};
            cmd_rdy_q <= 1'b1;
            state_q   <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end else if (timeout_d) begin
        state_q      <= IDLE;
        timer_q      <= '0;
        cmd_shadow_q <= '0;
        hi_shadow_q  <= '0;
        pkt_err_q    <= 1'b1;
      end else if (state_q != IDLE) begin
        timer_q <= timer_q + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cmd_pkt_assembler.sv
// Scoreboard bench for cmd_pkt_assembler: a queue-based packet model predicts
// completed packets and timeout errors; a negedge monitor checks what the DUT presents.
module tb_cmd_pkt_assembler;

  localparam int unsigned T = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  cmd_pkt_if bus ();

  cmd_pkt_assembler #(.TIMEOUT_CYC(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0]  pbuf[$];
  int          last_edge = 0;
  logic [23:0] pkt_q[$];
  int          err_q[$];

  // Monitor state
  logic        prev_rdy = 1'b0;
  logic [23:0] cur = '0;

  function automatic void model_accept(input logic [7:0] b, input int edge_idx);
    pbuf.push_back(b);
    last_edge = edge_idx;
    if (pbuf.size() == 3) begin
      pkt_q.push_back({pbuf[0], pbuf[1], pbuf[2]});
      pbuf.delete();
    end
  endfunction

  // The idle gap before the next accept is known up front; a partial packet
  // expires if no byte arrives within T edges of the last one.
  function automatic void model_gap(input int g);
    if (pbuf.size() != 0 && (g + 1) > int'(T)) begin
      err_q.push_back(last_edge + int'(T));
      pbuf.delete();
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one byte for a single cycle, then idle g cycles
  task automatic send_byte(input logic [7:0] b, input int g, input bit clr);
    bus.rx_rdy      = 1'b1;
    bus.rx_data     = b;
    bus.clr_cmd_rdy = clr;
    model_accept(b, cyc + 1);
    step();
    bus.rx_rdy      = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    model_gap(g);
    repeat (g) step();
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
    send_byte(c, 0, 1'b0);
    send_byte(h, 0, 1'b0);
    send_byte(l, 0, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_rdy"}, 32'(bus.cmd_rdy), 32'd0);
    check({tag, "_cmd"}, 32'(bus.cmd), 32'd0);
    check({tag, "_data"}, 32'(bus.data), 32'd0);
    check({tag, "_pkt_err"}, 32'(bus.pkt_err), 32'd0);
    check({tag, "_clr_rx_rdy"}, 32'(bus.clr_rx_rdy), 32'd0);
  endtask

  // Monitor: acknowledge tracking, packet completion, output stability, error pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rdy = 1'b0;
      cur      = '0;
    end else begin
      tests++;
      if (bus.clr_rx_rdy !== bus.rx_rdy) begin
        fails++;
        $display("FAIL clr_rx_rdy: got %b expected %b (t=%0t)", bus.clr_rx_rdy, bus.rx_rdy, $time);
      end
      tests++;
      if (bus.cmd_rdy === 1'b1 && !prev_rdy) begin
        if (pkt_q.size() == 0) begin
          fails++;
          $display("FAIL packet: unexpected %h (t=%0t)", {bus.cmd, bus.data}, $time);
        end else begin
          logic [23:0] exp;
          exp = pkt_q.pop_front();
          if ({bus.cmd, bus.data} !== exp) begin
            fails++;
            $display("FAIL packet: got %h expected %h (t=%0t)", {bus.cmd, bus.data}, exp, $time);
          end
        end
        cur = {bus.cmd, bus.data};
      end else if ({bus.cmd, bus.data} !== cur) begin
        fails++;
        $display("FAIL hold: got %h expected %h (t=%0t)", {bus.cmd, bus.data}, cur, $time);
        cur = {bus.cmd, bus.data};
      end
      if (bus.pkt_err !== 1'b0) begin
        tests++;
        if (err_q.size() == 0) begin
          fails++;
          $display("FAIL pkt_err: unexpected pulse at edge %0d", cyc);
        end else begin
          int e;
          e = err_q.pop_front();
          if (e != cyc) begin
            fails++;
            $display("FAIL pkt_err: got edge %0d expected %0d", cyc, e);
          end
        end
      end
      prev_rdy = (bus.cmd_rdy === 1'b1);
    end
  end

  initial begin
    bus.rx_rdy      = 1'b0;
    bus.rx_data     = '0;
    bus.clr_cmd_rdy = 1'b0;
    #3;
    check_reset_vals("por");
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Basic packet
    send_pkt(8'h05, 8'h12, 8'h34);
    check("basic_rdy", 32'(bus.cmd_rdy), 32'd1);
    check("basic_cmd", 32'(bus.cmd), 32'h05);
    check("basic_data", 32'(bus.data), 32'h1234);

    // Consumer clear leaves payload intact
    bus.clr_cmd_rdy = 1'b1;
    step();
    bus.clr_cmd_rdy = 1'b0;
    check("clr_rdy", 32'(bus.cmd_rdy), 32'd0);
    check("clr_cmd", 32'(bus.cmd), 32'h05);
    check("clr_data", 32'(bus.data), 32'h1234);

    // Byte 0 of the next packet clears cmd_rdy, payload held until completion
    send_pkt(8'h11, 8'h22, 8'h33);
    check("set_again", 32'(bus.cmd_rdy), 32'd1);
    send_byte(8'h0A, 0, 1'b0);
    check("b0_clears", 32'(bus.cmd_rdy), 32'd0);
    check("b0_hold_cmd", 32'(bus.cmd), 32'h11);
    send_byte(8'hBE, 0, 1'b0);
    send_byte(8'hEF, 0, 1'b0);
    check("beef_cmd", 32'(bus.cmd), 32'h0A);
    check("beef_data", 32'(bus.data), 32'hBEEF);

    // Timeout discards a two-byte partial packet
    send_byte(8'h07, 0, 1'b0);
    send_byte(8'h55, T, 1'b0);
    check("tmo_keeps_cmd", 32'(bus.cmd), 32'h0A);
    send_pkt(8'h01, 8'h00, 8'h02);
    check("after_tmo_cmd", 32'(bus.cmd), 32'h01);
    check("after_tmo_data", 32'(bus.data), 32'h0002);

    // Completion and consumer clear in the same cycle: set wins
    send_byte(8'h21, 0, 1'b0);
    send_byte(8'h43, 0, 1'b0);
    send_byte(8'h65, 0, 1'b1);
    check("set_wins", 32'(bus.cmd_rdy), 32'd1);
    check("set_wins_data", 32'(bus.data), 32'h4365);

    // Accept landing exactly on the timeout edge wins
    send_byte(8'h5A, T - 1, 1'b0);
    send_byte(8'h6B, T - 1, 1'b0);
    send_byte(8'h7C, 0, 1'b0);
    check("tie_cmd", 32'(bus.cmd), 32'h5A);
    check("tie_data", 32'(bus.data), 32'h6B7C);

    // Reset mid-packet
    send_byte(8'h09, 0, 1'b0);
    send_byte(8'h44, 1, 1'b0);
    rst_n = 1'b0;
    pbuf.delete();
    #2;
    check_reset_vals("mid_rst");
    step();
    step();
    rst_n = 1'b1;
    step();
    send_pkt(8'h03, 8'hAA, 8'h55);
    check("post_rst_cmd", 32'(bus.cmd), 32'h03);
    check("post_rst_data", 32'(bus.data), 32'hAA55);

    // Randomized byte stream with gaps around the timeout boundary
    for (int i = 0; i < 300; i++) begin
      int r;
      int g;
      r = int'($urandom_range(0, 9));
      if (r < 5)       g = 0;
      else if (r < 7)  g = int'($urandom_range(1, 5));
      else if (r == 7) g = int'(T) - 1;
      else if (r == 8) g = int'(T);
      else             g = int'(T) + 3;
      send_byte(8'($urandom_range(0, 255)), g, ($urandom_range(0, 3) == 0));
    end

    // Drain: let any partial packet expire
    model_gap(int'(T) + 5);
    repeat (T + 5) step();
    check("pkt_q_empty", 32'(pkt_q.size()), 32'd0);
    check("err_q_empty", 32'(err_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmd_pkt_assembler.md
# cmd_pkt_assembler

Consumes the byte stream produced by `uart_rcv` and assembles 3-byte command packets: command byte, data high byte, data low byte. Sits directly downstream of `uart_rcv` and upstream of the command-processing logic. It drives the receiver's `clr_rdy` to acknowledge each byte and presents a complete `{cmd, data}` with a `cmd_rdy` flag. An inter-byte timeout discards partial packets so the stream resynchronises after a dropped byte.

## Interface
- `TIMEOUT_CYC`, default 1_000_000: inter-byte timeout in clk cycles (10 ms at 100 MHz); legal range 2..2^20-1.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_rdy`  in  1  byte-available level from `uart_rcv.rdy`; held high until cleared.
- `rx_data`  in  8  received byte from `uart_rcv.rx_data`; valid while `rx_rdy`=1.
- `clr_rx_rdy`  out  1  byte acknowledge to `uart_rcv.clr_rdy`.
- `cmd_rdy`  out  1  complete packet available.
- `cmd`  out  8  command byte of the last complete packet.
- `data`  out  16  data word of the last complete packet, high byte first on the wire.
- `clr_cmd_rdy`  in  1  consumer acknowledge; clears `cmd_rdy`.
- `pkt_err`  out  1  one-cycle pulse when a partial packet is discarded on timeout.

## Operation
- States: `IDLE` (await byte 0), `HIGH` (await byte 1), `LOW` (await byte 2).
- Accept condition: `rx_rdy`=1 in any state.
  - `clr_rx_rdy` is combinational and equals the accept condition. It is asserted in the same cycle `rx_rdy` is seen, so `uart_rcv` drops `rdy` at that edge. This prevents a byte from being accepted twice.
- `IDLE` + accept:
  - `cmd_shadow` <= `rx_data`.
  - `cmd_rdy` <= 0, unless a completion sets it in the same cycle, which is impossible in `IDLE`.
  - Next state `HIGH`; timer <= 0.
- `HIGH` + accept: `hi_shadow` <= `rx_data`; next state `LOW`; timer <= 0.
- `LOW` + accept:
  - `cmd` <= `cmd_shadow`; `data` <= {`hi_shadow`, `rx_data`}; `cmd_rdy` <= 1.
  - Next state `IDLE`.
- `cmd`/`data` change only on packet completion. They stay stable while a following packet is being received.
- `cmd_rdy` clear sources:
  - `clr_cmd_rdy`=1.
  - Acceptance of byte 0 of the next packet.
- `cmd_rdy` set and clear in the same cycle: set wins.
- Timeout:
  - In `HIGH` or `LOW` with no accept, the 20-bit timer increments each cycle.
  - When timer == `TIMEOUT_CYC`-1: next state `IDLE`, timer <= 0, `pkt_err` pulses high for exactly one cycle (registered), shadow registers discarded.
  - `cmd`/`data`/`cmd_rdy` are unaffected by a timeout.
- Accept and timeout in the same cycle: accept wins, with no `pkt_err`.
- In `IDLE` the timer holds at 0 and no timeout occurs.

## Timing
- Reset values:
  - state `IDLE`; timer 0.
  - `cmd`=0x00, `data`=0x0000, `cmd_rdy`=0, `pkt_err`=0.
  - `clr_rx_rdy`=0, since it is combinational and `rx_rdy` is low out of reset.
- Latency: `cmd_rdy`, `cmd` and `data` update on the first rising edge at which byte 2 is accepted, and are visible the following cycle.
- Per accepted byte, `clr_rx_rdy` is high for exactly one cycle if `uart_rcv` clears at that edge.
- Back-to-back bytes on consecutive cycles are accepted, one per cycle.
- `pkt_err` rises TIMEOUT_CYC cycles after the last accepted byte of a partial packet.
- Reset asserted mid-packet returns all state to reset values immediately; the partial packet is lost and `pkt_err` is not asserted.

## Test plan
- Send bytes 0x05, 0x12, 0x34 via `uart_tx`→`uart_rcv`:
  - `cmd_rdy` rises with `cmd`=0x05 and `data`=0x1234.
  - `clr_rx_rdy` pulses three times, one cycle each.
- With `cmd_rdy`=1, pulse `clr_cmd_rdy` one cycle: `cmd_rdy`=0 next cycle, and `cmd`/`data` are unchanged.
- Leave `cmd_rdy` set and send byte 0x0A:
  - `cmd_rdy` clears on that accept.
  - `cmd` stays 0x05 until bytes 0xBE, 0xEF complete, then `cmd`=0x0A and `data`=0xBEEF.
- With `TIMEOUT_CYC`=1000, send 0x07 and 0x55, then wait 1000 cycles:
  - `pkt_err` is one single-cycle pulse and state returns to `IDLE`.
  - Then send 0x01, 0x00, 0x02: `cmd`=0x01, `data`=0x0002.
- Hold `rx_rdy` high directly, with no receiver, and pulse `clr_cmd_rdy` in the completion cycle: `cmd_rdy`=1, because set wins.
- Assert `rst_n` low after byte 1 of a packet:
  - All outputs return to reset values and `pkt_err` stays 0.
  - A following full packet 0x03, 0xAA, 0x55 yields `cmd`=0x03, `data`=0xAA55.
